// File: rtl/y86_mc_core.sv
// Multicycle y86-subset core: one-hot FETCH/DECODE/EXEC/MEM/WB sequencer plus a sticky HALT,
// with a ready-handshaked memory bus and configurable data/address widths.
module y86_mc_core #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_IP = '0,
    parameter int                BASE_REG = 6
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] bus_A,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_WE,
    output logic              bus_RE,
    input  logic              bus_rdy,
    output logic [7:0]        current_opcode,
    output logic              retired,
    output logic              halted,
    output logic              illegal
);
    localparam logic [2:0] BASE = 3'(BASE_REG);

    typedef enum logic [5:0] {
        S_FETCH  = 6'b000001,
        S_DECODE = 6'b000010,
        S_EXEC   = 6'b000100,
        S_MEM    = 6'b001000,
        S_WB     = 6'b010000,
        S_HALT   = 6'b100000
    } phase_t;

    phase_t            phase;
    logic [ADDR_W-1:0] ip;
    logic [23:0]       ir;
    logic [DATA_W-1:0] r [8];
    logic [DATA_W-1:0] a, b, res, mdr, out_q, alu;
    logic              zf, illegal_q;

    logic [7:0]        op;
    logic [1:0]        md;
    logic [2:0]        rd, rs;
    logic [DATA_W-1:0] disp8;
    logic [ADDR_W-1:0] rel8, ip_next;
    logic [1:0]        len;
    logic              is_add, is_sub, is_mov, is_ld, is_st, is_jz, is_jnz, is_nop, is_hlt, is_ill;
    logic              taken;

    assign op    = ir[7:0];
    assign md    = ir[15:14];
    assign rs    = ir[13:11];
    assign rd    = ir[10:8];
    assign disp8 = {{(DATA_W-8){ir[23]}}, ir[23:16]};
    assign rel8  = {{(ADDR_W-8){ir[15]}}, ir[15:8]};

    assign is_add = (op == 8'h01);
    assign is_sub = (op == 8'h29);
    assign is_mov = (op == 8'h89) && (md == 2'd3);
    assign is_st  = (op == 8'h89) && (md == 2'd1);
    assign is_ld  = (op == 8'h8B) && (md == 2'd1);
    assign is_jz  = (op == 8'h74);
    assign is_jnz = (op == 8'h75);
    assign is_nop = (op == 8'h90);
    assign is_hlt = (op == 8'hF4);
    assign is_ill = !(is_add || is_sub || is_mov || is_st || is_ld ||
                      is_jz || is_jnz || is_nop || is_hlt);

    assign len     = (is_ld || is_st) ? 2'd3 :
                     (is_add || is_sub || is_mov || is_jz || is_jnz) ? 2'd2 : 2'd1;
    assign taken   = (is_jz && zf) || (is_jnz && !zf);
    assign ip_next = ip + ADDR_W'(len) + (taken ? rel8 : '0);

    always_comb begin
        alu = a + b;
        if (is_sub)
            alu = a + ~b + DATA_W'(1);
        else if (is_ld || is_st)
            alu = a + disp8;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= S_FETCH;
            ip        <= RESET_IP;
            ir        <= '0;
            zf        <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 8; i++) r[i] <= '0;
        end else begin
            case (phase)
                S_FETCH: if (bus_rdy) begin
                    ir    <= bus_in[23:0];
                    phase <= S_DECODE;
                end
                S_DECODE: begin
                    a <= (is_ld || is_st) ? r[BASE] : r[rd];
                    b <= r[rs];
                    if (is_hlt) begin
                        phase <= S_HALT;
                    end else if (is_ill) begin
                        phase     <= S_HALT;
                        illegal_q <= 1'b1;
                    end else begin
                        ip    <= ip_next;
                        phase <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res <= alu;
                    if (is_add || is_sub) zf <= (alu == '0);
                    if (is_st) out_q <= b;
                    phase <= S_MEM;
                end
                S_MEM: begin
                    // Only real bus transfers wait on ready; other ops pass straight through.
                    if (is_ld) begin
                        if (bus_rdy) begin
                            mdr   <= bus_in;
                            phase <= S_WB;
                        end
                    end else if (is_st) begin
                        if (bus_rdy) phase <= S_WB;
                    end else begin
                        phase <= S_WB;
                    end
                end
                S_WB: begin
                    if (is_add || is_sub) r[rd] <= res;
                    else if (is_mov)      r[rd] <= b;
                    else if (is_ld)       r[rs] <= mdr;
                    phase <= S_FETCH;
                end
                default: phase <= phase;
            endcase
        end
    end

    always_comb begin
        bus_RE = 1'b0;
        bus_WE = 1'b0;
        bus_A  = '0;
        case (phase)
            S_FETCH: begin
                bus_RE = 1'b1;
                bus_A  = ip;
            end
            S_MEM: begin
                if (is_ld) begin
                    bus_RE = 1'b1;
                    bus_A  = res[ADDR_W-1:0];
                end else if (is_st) begin
                    bus_WE = 1'b1;
                    bus_A  = res[ADDR_W-1:0];
                end
            end
            default: ;
        endcase
    end

    assign bus_out        = out_q;
    assign current_opcode = op;
    assign retired        = (phase == S_WB);
    assign halted         = (phase == S_HALT);
    assign illegal        = illegal_q;
endmodule

// File: tb/tb_y86_mc_core.sv
// Bench for y86_mc_core: directed programs plus random programs checked against an ISA-level model,
// and a 64-bit instance for reset-during-wait and displacement sign extension.
module tb_y86_mc_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1, rdy = 1'b0;
    logic [31:0] bus_A, bus_in, bus_out;
    logic        bus_WE, bus_RE, retired, halted, illegal;
    logic [7:0]  cur_op;

    logic        rst64 = 1'b1, rdy64 = 1'b0;
    logic [63:0] bus_A64, bus_in64, bus_out64;
    logic        bus_WE64, bus_RE64, retired64, halted64, illegal64;
    logic [7:0]  cur_op64;

    logic [63:0] mem [256];
    logic [63:0] mmem [256];
    logic [63:0] mem64 [256];
    logic [31:0] mr [8];
    logic        mzf;
    logic [31:0] mip;

    int          npass = 0, ntot = 0, last_cyc;
    logic [31:0] st_a, st_d;

    always #5 clk = ~clk;

    assign bus_in   = mem[bus_A[7:0]][31:0];
    assign bus_in64 = mem64[bus_A64[7:0]];

    y86_mc_core dut (
        .clk(clk), .rst(rst), .bus_A(bus_A), .bus_in(bus_in), .bus_out(bus_out),
        .bus_WE(bus_WE), .bus_RE(bus_RE), .bus_rdy(rdy), .current_opcode(cur_op),
        .retired(retired), .halted(halted), .illegal(illegal)
    );

    y86_mc_core #(.DATA_W(64), .ADDR_W(64)) dut64 (
        .clk(clk), .rst(rst64), .bus_A(bus_A64), .bus_in(bus_in64), .bus_out(bus_out64),
        .bus_WE(bus_WE64), .bus_RE(bus_RE64), .bus_rdy(rdy64), .current_opcode(cur_op64),
        .retired(retired64), .halted(halted64), .illegal(illegal64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] ins(input logic [7:0] op, input logic [1:0] md,
                                        input logic [2:0] rs, input logic [2:0] rd,
                                        input logic [7:0] b2);
        return {40'h0, b2, md, rs, rd, op};
    endfunction

    function automatic logic [63:0] rand_ins();
        logic [63:0] w;
        int k;
        w = {$urandom(), $urandom()};
        k = $urandom_range(0, 99);
        if (k < 15)      w[7:0] = 8'h01;
        else if (k < 30) w[7:0] = 8'h29;
        else if (k < 40) begin w[7:0] = 8'h89; w[15:14] = 2'd3; end
        else if (k < 55) begin w[7:0] = 8'h8B; w[15:14] = 2'd1; end
        else if (k < 62) begin w[7:0] = 8'h89; w[15:14] = 2'd1; end
        else if (k < 72) w[7:0] = 8'h74;
        else if (k < 82) w[7:0] = 8'h75;
        else if (k < 96) w[7:0] = 8'h90;
        else if (k < 97) w[7:0] = 8'hF4;
        else if (k < 98) begin w[7:0] = 8'h8B; w[15:14] = 2'd2; end
        else             w[7:0] = 8'h00;
        return w;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mr[i] = '0;
        for (int i = 0; i < 256; i++) mmem[i] = mem[i];
        mzf = 1'b0;
        mip = '0;
    endtask

    // Runs one instruction on the ISA model and on the DUT, then compares bus traffic and state.
    // fw/mw: wait cycles in fetch/memory (negative = random).
    task automatic run_instr(input int fw, input int mw, output bit stopped);
        logic [31:0] pre_ip, w, d8, rl, ea, ed, fa, la, sa, sd, prev_a;
        logic [7:0]  op;
        logic [1:0]  md;
        logic [2:0]  rd, rs;
        bit          e_hlt, e_ill, e_ld, e_st, seen_ret, seen_hlt;
        int          seg, wcnt, waits, ncyc, nld, nst, want;

        pre_ip = mip;
        w  = mmem[mip[7:0]][31:0];
        op = w[7:0]; md = w[15:14]; rs = w[13:11]; rd = w[10:8];
        d8 = {{24{w[23]}}, w[23:16]};
        rl = {{24{w[15]}}, w[15:8]};
        e_hlt = 0; e_ill = 0; e_ld = 0; e_st = 0; ea = '0; ed = '0;
        case (op)
            8'h01: begin mr[rd] = mr[rd] + mr[rs]; mzf = (mr[rd] == 0); mip = mip + 2; end
            8'h29: begin mr[rd] = mr[rd] - mr[rs]; mzf = (mr[rd] == 0); mip = mip + 2; end
            8'h89: begin
                if (md == 2'd3) begin mr[rd] = mr[rs]; mip = mip + 2; end
                else if (md == 2'd1) begin
                    e_st = 1; ea = mr[6] + d8; ed = mr[rs];
                    mmem[ea[7:0]] = {32'h0, ed};
                    mip = mip + 3;
                end else e_ill = 1;
            end
            8'h8B: begin
                if (md == 2'd1) begin
                    e_ld = 1; ea = mr[6] + d8;
                    mr[rs] = mmem[ea[7:0]][31:0];
                    mip = mip + 3;
                end else e_ill = 1;
            end
            8'h74: mip = mip + 2 + (mzf ? rl : 32'h0);
            8'h75: mip = mip + 2 + (!mzf ? rl : 32'h0);
            8'h90: mip = mip + 1;
            8'hF4: e_hlt = 1;
            default: e_ill = 1;
        endcase

        seg = 0; wcnt = 0; waits = 0; nld = 0; nst = 0; ncyc = 0;
        seen_ret = 0; seen_hlt = 0;
        fa = '1; la = '0; sa = '0; sd = '0; prev_a = '0;
        for (int c = 1; c <= 80; c++) begin
            ncyc = c;
            check("strobe_excl", {63'h0, bus_RE & bus_WE}, 64'h0);
            if (bus_RE || bus_WE) begin
                want = (seg == 0) ? fw : mw;
                if (want < 0) rdy = ($urandom_range(0, 2) != 0);
                else          rdy = (wcnt >= want);
                if (wcnt > 0) check("wait_stable", bus_A, prev_a);
                prev_a = bus_A;
                if (rdy) begin
                    if (seg == 0) fa = bus_A;
                    else if (bus_RE) begin la = bus_A; nld++; end
                    else begin
                        sa = bus_A; sd = bus_out; nst++;
                        mem[bus_A[7:0]] = {32'h0, bus_out};
                    end
                    seg++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                    waits++;
                end
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            if (retired) seen_ret = 1;
            if (halted)  seen_hlt = 1;
            if (seen_ret || seen_hlt) break;
        end

        check("fetch_addr", fa, pre_ip);
        check("opcode", cur_op, op);
        if (e_hlt || e_ill) begin
            check("halted", {63'h0, seen_hlt}, 64'h1);
            check("illegal", {63'h0, illegal}, {63'h0, e_ill});
            check("ip_hold", dut.ip, mip);
            for (int c = 0; c < 3; c++) begin
                check("halt_quiet", {bus_RE, bus_WE, retired, bus_A}, 64'h0);
                @(posedge clk); #1;
            end
            stopped = 1;
        end else begin
            check("retired", {63'h0, seen_ret}, 64'h1);
            check("cycles", ncyc + 1, 5 + waits);
            check("n_ld", nld, e_ld);
            check("n_st", nst, e_st);
            if (e_ld) check("ld_addr", la, ea);
            if (e_st) begin
                check("st_addr", sa, ea);
                check("st_data", sd, ed);
            end
            @(posedge clk); #1;
            for (int i = 0; i < 8; i++) check("reg", dut.r[i], mr[i]);
            check("zf", {63'h0, dut.zf}, {63'h0, mzf});
            check("ip", dut.ip, mip);
            stopped = 0;
        end
        last_cyc = ncyc + 1;
        st_a = sa;
        st_d = sd;
    endtask

    initial begin
        bit stp;

        // Program 1: load, add, sub to zero, taken jz, untaken jnz, halt
        clear_mem();
        mem[0]    = ins(8'h8B, 2'd1, 3'd2, 3'd0, 8'h40);
        mem[3]    = ins(8'h01, 2'd3, 3'd2, 3'd1, 8'h00);
        mem[5]    = ins(8'h29, 2'd3, 3'd1, 3'd1, 8'h00);
        mem[7]    = {48'h0, 8'h04, 8'h74};
        mem[13]   = {48'h0, 8'h04, 8'h75};
        mem[15]   = {56'h0, 8'hF4};
        mem[8'h40] = 64'h5;
        reset_dut();
        check("rst_re", {63'h0, bus_RE}, 64'h1);
        check("rst_we", {63'h0, bus_WE}, 64'h0);
        check("rst_a", bus_A, 64'h0);
        check("rst_flags", {61'h0, retired, halted, illegal}, 64'h0);
        check("rst_op", cur_op, 64'h0);
        run_instr(0, 0, stp);
        check("p1_r2", dut.r[2], 64'h5);
        run_instr(0, 0, stp);
        check("p1_r1", dut.r[1], 64'h5);
        check("p1_zf0", {63'h0, dut.zf}, 64'h0);
        check("p1_ip5", dut.ip, 64'h5);
        run_instr(0, 0, stp);
        check("p1_zf1", {63'h0, dut.zf}, 64'h1);
        run_instr(0, 0, stp);
        check("p1_jz", dut.ip, 64'd13);
        run_instr(0, 0, stp);
        check("p1_jnz", dut.ip, 64'd15);
        run_instr(0, 0, stp);
        check("p1_halt_ill", {63'h0, illegal}, 64'h0);
        check("p1_halt_ip", dut.ip, 64'd15);

        // Program 2: load with fetch/mem wait states, then opcode 0x00
        clear_mem();
        mem[0]    = ins(8'h8B, 2'd1, 3'd4, 3'd0, 8'h40);
        mem[8'h40] = 64'h7;
        reset_dut();
        run_instr(3, 2, stp);
        check("p2_cycles", last_cyc, 64'd10);
        run_instr(0, 0, stp);
        check("p2_illegal", {62'h0, halted, illegal}, 64'h3);

        // Program 3: store with negative-looking displacement
        clear_mem();
        mem[0]    = ins(8'h8B, 2'd1, 3'd6, 3'd0, 8'h20);
        mem[3]    = ins(8'h8B, 2'd1, 3'd3, 3'd0, 8'h10);
        mem[6]    = ins(8'h89, 2'd1, 3'd3, 3'd0, 8'hFC);
        mem[9]    = {56'h0, 8'hF4};
        mem[8'h20] = 64'h100;
        mem[8'h10] = 64'hDEADBEEF;
        reset_dut();
        for (int i = 0; i < 3; i++) run_instr(0, 0, stp);
        check("p3_st_a", st_a, 64'hFC);
        check("p3_st_d", st_d, 64'hDEADBEEF);
        run_instr(0, 0, stp);

        // Program 4: reset while a store is waiting for ready
        clear_mem();
        mem[0]    = ins(8'h8B, 2'd1, 3'd5, 3'd0, 8'h40);
        mem[3]    = ins(8'h89, 2'd1, 3'd5, 3'd0, 8'h30);
        mem[8'h40] = 64'h5;
        reset_dut();
        run_instr(0, 0, stp);
        for (int c = 0; c < 20 && !bus_WE; c++) begin
            rdy = 1'b1;
            @(posedge clk); #1;
        end
        rdy = 1'b0;
        check("p4_we", {63'h0, bus_WE}, 64'h1);
        @(posedge clk); #1;
        check("p4_we_hold", {63'h0, bus_WE}, 64'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("p4_rst_we", {63'h0, bus_WE}, 64'h0);
        check("p4_rst_re", {63'h0, bus_RE}, 64'h1);
        check("p4_rst_a", bus_A, 64'h0);
        check("p4_rst_ip", dut.ip, 64'h0);
        for (int i = 0; i < 8; i++) check("p4_rst_reg", dut.r[i], 64'h0);

        // Random programs with random wait states
        for (int e = 0; e < 8; e++) begin
            for (int i = 0; i < 256; i++) mem[i] = rand_ins();
            reset_dut();
            for (int n = 0; n < 120; n++) begin
                run_instr(-1, -1, stp);
                if (stp) break;
            end
        end
        rst = 1'b1;

        // 64-bit instance: sign-extended disp8=0x80, then reset mid store wait
        for (int i = 0; i < 256; i++) mem64[i] = '0;
        mem64[0]     = ins(8'h8B, 2'd1, 3'd6, 3'd0, 8'h10);
        mem64[3]     = ins(8'h89, 2'd1, 3'd6, 3'd0, 8'h80);
        mem64[8'h10] = 64'h1_0000_0100;
        rst64 = 1'b1;
        @(posedge clk); #1;
        rst64 = 1'b0;
        rdy64 = 1'b1;
        for (int c = 0; c < 40 && !bus_WE64; c++) begin
            @(posedge clk); #1;
        end
        check("w64_we", {63'h0, bus_WE64}, 64'h1);
        check("w64_addr", bus_A64, 64'h1_0000_0080);
        check("w64_data", bus_out64, 64'h1_0000_0100);
        rdy64 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("w64_hold", {bus_WE64, bus_A64[62:0]}, {1'b1, 63'h1_0000_0080});
        rst64 = 1'b1;
        @(posedge clk); #1;
        rst64 = 1'b0;
        check("w64_rst_we", {63'h0, bus_WE64}, 64'h0);
        check("w64_rst_re", {63'h0, bus_RE64}, 64'h1);
        check("w64_rst_a", bus_A64, 64'h0);
        check("w64_rst_flags", {53'h0, retired64, halted64, illegal64, cur_op64}, 64'h0);
        for (int i = 0; i < 8; i++) check("w64_rst_reg", dut64.r[i], 64'h0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
